control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 161 ++++++++++++++++
 tb/tb_control_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: steps one instruction through T0..T6 and
// drives datapath bus-source, load, ALU-select and status signals from the state.
`timescale 1ns/1ps
module control_sequencer #(
    parameter int  REG_SEL_W = 4,
    parameter int  CTL_W     = 5,
    localparam int REGS      = 2 ** REG_SEL_W
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             MemRdy,
    input  logic [31:0]      IR,
    output logic             PC_Out,
    output logic             ZLO_Out,
    output logic             ZHI_Out,
    output logic             MDR_Out,
    output logic             C_Out,
    output logic             MAR_In,
    output logic             PC_In,
    output logic             MDR_In,
    output logic             IR_In,
    output logic             Y_In,
    output logic             Z_In,
    output logic             LO_In,
    output logic             HI_In,
    output logic             IncPC,
    output logic             Read,
    output logic [REGS-1:0]  Reg_Out,
    output logic [REGS-1:0]  Reg_In,
    output logic [CTL_W-1:0] CONTROL,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 t1_repeat;
    logic [4:0]           opcode;
    logic [REG_SEL_W-1:0] ra;
    logic [REG_SEL_W-1:0] rb;
    logic [REG_SEL_W-1:0] rc;
    logic                 is_imm_alu;
    logic                 is_muldiv;
    logic                 is_legal;
    logic                 unused_ir;

    assign opcode     = IR[31:27];
    assign ra         = IR[26 -: REG_SEL_W];
    assign rb         = IR[22 -: REG_SEL_W];
    assign rc         = IR[18 -: REG_SEL_W];
    assign is_imm_alu = (opcode >= 5'd12) && (opcode <= 5'd14);
    assign is_muldiv  = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_legal   = (opcode <= 5'd16);
    assign unused_ir  = ^IR;

    // t1_repeat marks the memory-wait cycles of T1, so the PC update happens once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            t1_repeat <= 1'b0;
        end else begin
            state     <= state_next;
            t1_repeat <= (state == T1);
        end
    end

    always_comb begin
        state_next = state;
        PC_Out     = 1'b0;
        ZLO_Out    = 1'b0;
        ZHI_Out    = 1'b0;
        MDR_Out    = 1'b0;
        C_Out      = 1'b0;
        MAR_In     = 1'b0;
        PC_In      = 1'b0;
        MDR_In     = 1'b0;
        IR_In      = 1'b0;
        Y_In       = 1'b0;
        Z_In       = 1'b0;
        LO_In      = 1'b0;
        HI_In      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Reg_Out    = '0;
        Reg_In     = '0;
        CONTROL    = '0;
        Done       = 1'b0;
        Illegal    = 1'b0;
        Busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (Start) state_next = T0;
            end
            T0: begin
                PC_Out     = 1'b1;
                MAR_In     = 1'b1;
                IncPC      = 1'b1;
                Z_In       = 1'b1;
                state_next = T1;
            end
            T1: begin
                ZLO_Out = !t1_repeat;
                PC_In   = !t1_repeat;
                Read    = 1'b1;
                MDR_In  = 1'b1;
                if (MemRdy) state_next = T2;
            end
            T2: begin
                MDR_Out    = 1'b1;
                IR_In      = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (is_legal) begin
                    Reg_Out    = REGS'(1) << rb;
                    Y_In       = 1'b1;
                    state_next = T4;
                end else begin
                    Illegal    = 1'b1;
                    state_next = IDLE;
                end
            end
            T4: begin
                CONTROL = CTL_W'(opcode);
                Z_In    = 1'b1;
                if (is_imm_alu) C_Out = 1'b1;
                else            Reg_Out = REGS'(1) << rc;
                state_next = T5;
            end
            T5: begin
                ZLO_Out = 1'b1;
                if (is_muldiv) begin
                    LO_In      = 1'b1;
                    state_next = T6;
                end else begin
                    // R0 is hardwired; the write is suppressed but timing is kept.
                    if (ra != '0) Reg_In = REGS'(1) << ra;
                    state_next = DONE;
                end
            end
            T6: begin
                ZHI_Out    = 1'b1;
                HI_In      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: hand-derived per-cycle output words are
// queued per instruction and a monitor compares every busy/idle cycle against them.
`timescale 1ns/1ps
module tb_control_sequencer;
    localparam int REG_SEL_W = 4;
    localparam int CTL_W     = 5;
    localparam int REGS      = 16;
    localparam int OW        = 2 * REGS + CTL_W + 18;

    localparam logic [OW-1:0] ONE       = 1;
    localparam logic [OW-1:0] M_PC_OUT  = ONE << 0;
    localparam logic [OW-1:0] M_ZLO_OUT = ONE << 1;
    localparam logic [OW-1:0] M_ZHI_OUT = ONE << 2;
    localparam logic [OW-1:0] M_MDR_OUT = ONE << 3;
    localparam logic [OW-1:0] M_C_OUT   = ONE << 4;
    localparam logic [OW-1:0] M_MAR_IN  = ONE << 5;
    localparam logic [OW-1:0] M_PC_IN   = ONE << 6;
    localparam logic [OW-1:0] M_MDR_IN  = ONE << 7;
    localparam logic [OW-1:0] M_IR_IN   = ONE << 8;
    localparam logic [OW-1:0] M_Y_IN    = ONE << 9;
    localparam logic [OW-1:0] M_Z_IN    = ONE << 10;
    localparam logic [OW-1:0] M_LO_IN   = ONE << 11;
    localparam logic [OW-1:0] M_HI_IN   = ONE << 12;
    localparam logic [OW-1:0] M_INCPC   = ONE << 13;
    localparam logic [OW-1:0] M_READ    = ONE << 14;
    localparam logic [OW-1:0] M_BUSY    = ONE << 15;
    localparam logic [OW-1:0] M_DONE    = ONE << 16;
    localparam logic [OW-1:0] M_ILLEGAL = ONE << 17;

    logic             Clock = 1'b0;
    logic             Reset_n = 1'b1;
    logic             Start = 1'b0;
    logic             MemRdy = 1'b1;
    logic [31:0]      IR = '0;
    logic             PC_Out, ZLO_Out, ZHI_Out, MDR_Out, C_Out;
    logic             MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, LO_In, HI_In;
    logic             IncPC, Read, Busy, Done, Illegal;
    logic [REGS-1:0]  Reg_Out, Reg_In;
    logic [CTL_W-1:0] CONTROL;
    logic [OW-1:0]    obs;

    logic [OW-1:0]    exp_q[$];
    int               lat_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               start_cyc = 0;

    control_sequencer #(.REG_SEL_W(REG_SEL_W), .CTL_W(CTL_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .MemRdy(MemRdy), .IR(IR),
        .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out), .MDR_Out(MDR_Out),
        .C_Out(C_Out), .MAR_In(MAR_In), .PC_In(PC_In), .MDR_In(MDR_In),
        .IR_In(IR_In), .Y_In(Y_In), .Z_In(Z_In), .LO_In(LO_In), .HI_In(HI_In),
        .IncPC(IncPC), .Read(Read), .Reg_Out(Reg_Out), .Reg_In(Reg_In),
        .CONTROL(CONTROL), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    assign obs = {Reg_In, Reg_Out, CONTROL, Illegal, Done, Busy, Read, IncPC,
                  HI_In, LO_In, Z_In, Y_In, IR_In, MDR_In, PC_In, MAR_In,
                  C_Out, MDR_Out, ZHI_Out, ZLO_Out, PC_Out};

    // Clock and cycle counter
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [OW-1:0] ro(input int n);
        return ONE << (23 + n);
    endfunction

    function automatic logic [OW-1:0] ri(input int n);
        return ONE << (39 + n);
    endfunction

    function automatic logic [OW-1:0] ctl(input int v);
        return OW'(v) << 18;
    endfunction

    // Monitor: every busy cycle consumes one expected word; idle cycles must be silent.
    always @(negedge Clock) begin
        if (Busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_busy cycle=%0d got=%h required=idle", cyc, obs);
            end else begin
                logic [OW-1:0] exp_w;
                exp_w = exp_q.pop_front();
                if (obs !== exp_w) begin
                    failures++;
                    $display("FAIL trace cycle=%0d got=%h required=%h", cyc, obs, exp_w);
                end
            end
            if (Done) begin
                checks++;
                if (lat_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done cycle=%0d", cyc);
                end else begin
                    int exp_lat;
                    exp_lat = lat_q.pop_front();
                    if (cyc - start_cyc + 1 != exp_lat) begin
                        failures++;
                        $display("FAIL done_latency got=%0d required=%0d",
                                 cyc - start_cyc + 1, exp_lat);
                    end
                end
            end
        end else begin
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%h required=0", cyc, obs);
            end
        end
    end

    task automatic push_fetch(input int n_wait);
        exp_q.push_back(M_BUSY | M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN);
        for (int i = 0; i < n_wait; i++) exp_q.push_back(M_BUSY | M_READ | M_MDR_IN);
        exp_q.push_back(M_BUSY | M_MDR_OUT | M_IR_IN);
    endtask

    // Issues one Start; returns mid cycle 1 (or later when memory waits/hold apply).
    task automatic run(input logic [31:0] ir, input int n_wait, input bit hold,
                       input int lat);
        @(negedge Clock);
        IR     = ir;
        MemRdy = (n_wait == 0);
        Start  = 1'b1;
        if (lat > 0) lat_q.push_back(lat);
        @(posedge Clock);
        @(negedge Clock);
        start_cyc = cyc;
        if (!hold) Start = 1'b0;
        if (n_wait > 0) begin
            repeat (n_wait + 1) @(posedge Clock);
            @(negedge Clock);
            MemRdy = 1'b1;
        end
        if (hold) begin
            repeat (4) @(negedge Clock);
            Start = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0) && (guard < 40)) begin
            @(negedge Clock);
            guard++;
        end
        @(negedge Clock);
        #1;
        checks++;
        if ((exp_q.size() != 0) || (lat_q.size() != 0)) begin
            failures++;
            $display("FAIL drain words_left=%0d done_pending=%0d required=0/0",
                     exp_q.size(), lat_q.size());
            exp_q.delete();
            lat_q.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0", obs);
        end
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        // add R5,R2,R4
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(2) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(4) | ctl(0) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | ri(5));
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h0292_0000, 0, 1'b0, 7);
        drain();

        // addi R3,R1,5
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(1) | M_Y_IN);
        exp_q.push_back(M_BUSY | M_C_OUT | ctl(12) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | ri(3));
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h6188_0005, 0, 1'b0, 7);
        drain();

        // opcode 01110, last immediate class: Ra=7, Rb=8
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(8) | M_Y_IN);
        exp_q.push_back(M_BUSY | M_C_OUT | ctl(14) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | ri(7));
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h73C0_0000, 0, 1'b0, 7);
        drain();

        // mul R6,R7 with three memory wait cycles
        push_fetch(3);
        exp_q.push_back(M_BUSY | ro(6) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(7) | ctl(15) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | M_LO_IN);
        exp_q.push_back(M_BUSY | M_ZHI_OUT | M_HI_IN);
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h7833_8000, 3, 1'b0, 11);
        drain();

        // div R1,R2
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(1) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(2) | ctl(16) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | M_LO_IN);
        exp_q.push_back(M_BUSY | M_ZHI_OUT | M_HI_IN);
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h8009_0000, 0, 1'b0, 8);
        drain();

        // illegal 11111 with Start held high through the sequence
        push_fetch(0);
        exp_q.push_back(M_BUSY | M_ILLEGAL);
        run(32'hF800_0000, 0, 1'b1, 0);
        drain();

        // illegal 10001, first opcode past DIV
        push_fetch(0);
        exp_q.push_back(M_BUSY | M_ILLEGAL);
        run(32'h8800_0000, 0, 1'b0, 0);
        drain();

        // Ra=0: write suppressed, Done timing unchanged
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(2) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(4) | ctl(0) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT);
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h0012_0000, 0, 1'b0, 7);
        drain();

        // reset asserted in the middle of T4 of an add
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(2) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(4) | ctl(0) | M_Z_IN);
        run(32'h0292_0000, 0, 1'b0, 0);
        repeat (4) @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h required=0", obs);
        end
        @(negedge Clock);
        #2 Reset_n = 1'b1;
        repeat (6) @(negedge Clock);
        drain();

        // normal add after reset recovery
        push_fetch(0);
        exp_q.push_back(M_BUSY | ro(2) | M_Y_IN);
        exp_q.push_back(M_BUSY | ro(4) | ctl(0) | M_Z_IN);
        exp_q.push_back(M_BUSY | M_ZLO_OUT | ri(5));
        exp_q.push_back(M_BUSY | M_DONE);
        run(32'h0292_0000, 0, 1'b0, 7);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog time_limit_reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
